// File: rtl/aes_sub_bytes_sched_if.sv
// Request/response bundle between the round controller / key scheduler and the
// shared SubBytes engine. The master side is the requester, the slave side the engine.
interface aes_sub_bytes_sched_if;
    logic         blk_req_valid;
    logic         blk_req_ready;
    logic         blk_enc;
    logic [127:0] blk_in;
    logic         blk_out_valid;
    logic         blk_out_ready;
    logic [127:0] blk_out;
    logic         key_req_valid;
    logic         key_req_ready;
    logic [31:0]  key_in;
    logic         key_out_valid;
    logic         key_out_ready;
    logic [31:0]  key_out;

    modport master (
        output blk_req_valid, blk_enc, blk_in, blk_out_ready,
        output key_req_valid, key_in, key_out_ready,
        input  blk_req_ready, blk_out_valid, blk_out,
        input  key_req_ready, key_out_valid, key_out
    );

    modport slave (
        input  blk_req_valid, blk_enc, blk_in, blk_out_ready,
        input  key_req_valid, key_in, key_out_ready,
        output blk_req_ready, blk_out_valid, blk_out,
        output key_req_ready, key_out_valid, key_out
    );
endinterface

// File: rtl/aes_sub_bytes_sched.sv
// Time-multiplexed SubBytes engine: LANES S-box pairs shared by a 128-bit round job and a
// 32-bit SubWord job. Define AES_SUB_SCHED_RR_EN for round-robin arbitration (default: key wins).
module aes_sub_bytes_sched #(
    parameter int unsigned LANES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    aes_sub_bytes_sched_if.slave      bus,
    output logic                      busy
);

    localparam int unsigned NChunk = 16 / LANES;
    localparam int unsigned CntW   = (NChunk > 1) ? $clog2(NChunk) : 1;

    if (LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("aes_sub_bytes_sched: LANES must be 4, 8 or 16");
    end

    typedef enum logic [2:0] {StIdle, StBlkRun, StKeyRun, StBlkDone, StKeyDone} state_e;

    state_e            state_q, state_d;
    logic [127:0]      work_q, work_d;
    logic              mode_q, mode_d;
    logic [CntW-1:0]   chunk_q, chunk_d;
`ifdef AES_SUB_SCHED_RR_EN
    logic              rr_q, rr_d;     // 1 = key preferred on contention
    logic              both_valid;
`endif

    logic              grant_key, grant_blk;
    logic              key_rdy, blk_rdy;
    logic              key_acc, blk_acc;
    logic              last_chunk;
    logic [3:0]        lane_idx [LANES];
    logic [7:0]        lane_out [LANES];

    // GF(2^8) arithmetic modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 as SubBytes requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] aes_sbox(input logic [7:0] a);
        logic [7:0] i;
        i = gf_inv(a);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] aes_inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] lane_in;
        assign lane_idx[l] = 4'(int'(chunk_q) * int'(LANES) + l);
        assign lane_in     = work_q[{lane_idx[l], 3'b000} +: 8];
        assign lane_out[l] = mode_q ? aes_sbox(lane_in) : aes_inv_sbox(lane_in);
    end

    assign last_chunk = (chunk_q == CntW'(NChunk - 1));
    assign key_acc    = bus.key_req_valid && key_rdy;
    assign blk_acc    = bus.blk_req_valid && blk_rdy;
`ifdef AES_SUB_SCHED_RR_EN
    assign both_valid = bus.key_req_valid && bus.blk_req_valid;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            work_q  <= '0;
            mode_q  <= 1'b0;
            chunk_q <= '0;
`ifdef AES_SUB_SCHED_RR_EN
            rr_q    <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            mode_q  <= mode_d;
            chunk_q <= chunk_d;
`ifdef AES_SUB_SCHED_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (key_acc)      state_d = StKeyRun;
                else if (blk_acc) state_d = StBlkRun;
            end
            StBlkRun:  if (last_chunk) state_d = StBlkDone;
            StKeyRun:  state_d = StKeyDone;
            StBlkDone: if (bus.blk_out_ready) state_d = StIdle;
            StKeyDone: if (bus.key_out_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        work_d  = work_q;
        mode_d  = mode_q;
        chunk_d = chunk_q;
`ifdef AES_SUB_SCHED_RR_EN
        rr_d = rr_q;
        if ((key_acc || blk_acc) && both_valid) rr_d = !key_acc;
`endif
        if (key_acc) begin
            work_d[31:0] = bus.key_in;
            mode_d       = 1'b1;
            chunk_d      = '0;
        end else if (blk_acc) begin
            work_d  = bus.blk_in;
            mode_d  = bus.blk_enc;
            chunk_d = '0;
        end else if (state_q == StBlkRun || state_q == StKeyRun) begin
            // Substitute the current chunk in place.
            for (int l = 0; l < LANES; l++) begin
                work_d[{lane_idx[l], 3'b000} +: 8] = lane_out[l];
            end
            chunk_d = (state_q == StBlkRun && !last_chunk) ? chunk_q + CntW'(1) : '0;
        end
    end

    always_comb begin
`ifdef AES_SUB_SCHED_RR_EN
        grant_key = bus.key_req_valid && (!bus.blk_req_valid || rr_q);
`else
        grant_key = bus.key_req_valid;
`endif
        grant_blk         = bus.blk_req_valid && !grant_key;
        key_rdy           = !rst && (state_q == StIdle) && grant_key;
        blk_rdy           = !rst && (state_q == StIdle) && grant_blk;
        bus.key_req_ready = key_rdy;
        bus.blk_req_ready = blk_rdy;
        busy              = (state_q != StIdle);
        bus.blk_out_valid = (state_q == StBlkDone);
        bus.key_out_valid = (state_q == StKeyDone);
        bus.blk_out       = (state_q == StBlkDone) ? work_q : '0;
        bus.key_out       = (state_q == StKeyDone) ? work_q[31:0] : '0;
    end

endmodule

// File: tb/tb_aes_sub_bytes_sched.sv
// Self-checking bench for aes_sub_bytes_sched: vector table, arbitration order,
// output backpressure and mid-job reset. Honours AES_SUB_SCHED_RR_EN.
module tb_aes_sub_bytes_sched;

    parameter int unsigned LANES = 4;
    localparam int NCHUNK = 16 / LANES;

    typedef struct {
        logic         is_key;
        logic         enc;
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   checks = 0;
    int   failures = 0;

    logic [127:0] cur_blk_exp;
    logic [31:0]  cur_key_exp;
    logic [127:0] exp_blk [$];
    logic [31:0]  exp_key [$];
    logic         acc_q [$];   // 1 = key accepted, 0 = block accepted

    aes_sub_bytes_sched_if bus();

    aes_sub_bytes_sched #(.LANES(LANES)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Scoreboard: push at accept, pop and compare at output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.blk_req_valid && bus.blk_req_ready) begin
                exp_blk.push_back(cur_blk_exp);
                acc_q.push_back(1'b0);
            end
            if (bus.key_req_valid && bus.key_req_ready) begin
                exp_key.push_back(cur_key_exp);
                acc_q.push_back(1'b1);
            end
            check("one_ready", 128'(bus.blk_req_ready & bus.key_req_ready), 128'(0));
            check("one_valid", 128'(bus.blk_out_valid & bus.key_out_valid), 128'(0));
            if (bus.blk_out_valid && bus.blk_out_ready) begin
                checks++;
                if (exp_blk.size() == 0) begin
                    failures++;
                    $display("FAIL blk_unexpected: got %0h, want no output", bus.blk_out);
                end else begin
                    checks--;
                    check("blk_out", bus.blk_out, exp_blk.pop_front());
                end
            end
            if (bus.key_out_valid && bus.key_out_ready) begin
                checks++;
                if (exp_key.size() == 0) begin
                    failures++;
                    $display("FAIL key_unexpected: got %0h, want no output", bus.key_out);
                end else begin
                    checks--;
                    check("key_out", 128'(bus.key_out), 128'(exp_key.pop_front()));
                end
            end
        end
    end

    task automatic wait_accept(input logic is_key);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_key ? bus.key_req_ready : bus.blk_req_ready) && n < 50);
        check("accept_seen", 128'(is_key ? bus.key_req_ready : bus.blk_req_ready), 128'(1));
    endtask

    // Call right after the accept edge; lat counts edges from accept to out_valid.
    task automatic wait_done(input logic is_key, output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            check("busy_run", 128'(busy), 128'(1));
            if (is_key ? bus.key_out_valid : bus.blk_out_valid) break;
            lat++;
            if (is_key) bus.blk_enc = ~bus.blk_enc;
            if (lat > 40) begin
                checks++;
                failures++;
                $display("FAIL done_timeout: got no out_valid, want one within 40 cycles");
                break;
            end
        end
    endtask

    task automatic check_idle(input string name);
        check(name, {125'(0), busy, bus.blk_out_valid, bus.key_out_valid}, 128'(0));
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        @(posedge clk); #1;
        if (v.is_key) begin
            bus.key_req_valid = 1'b1;
            bus.key_in        = v.din[31:0];
            cur_key_exp       = v.dout[31:0];
        end else begin
            bus.blk_req_valid = 1'b1;
            bus.blk_in        = v.din;
            bus.blk_enc       = v.enc;
            cur_blk_exp       = v.dout;
        end
        wait_accept(v.is_key);
        @(posedge clk); #1;
        bus.key_req_valid = 1'b0;
        bus.blk_req_valid = 1'b0;
        if (!v.is_key) begin
            bus.blk_in  = ~v.din;
            bus.blk_enc = ~v.enc;
        end
        wait_done(v.is_key, lat);
        check(v.is_key ? "key_latency" : "blk_latency", 128'(lat), 128'(v.is_key ? 1 : NCHUNK));
        @(negedge clk);
        check_idle("idle_after_job");
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_blk.size() != 0 || exp_key.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", 128'(exp_blk.size() + exp_key.size()), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before 500000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       vecs [9];
        logic [2:0] exp_order;
        int         lat;
        int         n;

        vecs[0] = '{1'b0, 1'b1, {16{8'h00}}, {16{8'h63}}};
        vecs[1] = '{1'b0, 1'b0, {16{8'h63}}, {16{8'h00}}};
        vecs[2] = '{1'b0, 1'b1, {16{8'h53}}, {16{8'hed}}};
        vecs[3] = '{1'b0, 1'b0, {16{8'hed}}, {16{8'h53}}};
        vecs[4] = '{1'b0, 1'b1, 128'h0f0e0d0c0b0a09080706050403020100,
                                128'h76abd7fe2b670130c56f6bf27b777c63};
        vecs[5] = '{1'b0, 1'b0, 128'h76abd7fe2b670130c56f6bf27b777c63,
                                128'h0f0e0d0c0b0a09080706050403020100};
        vecs[6] = '{1'b1, 1'b0, 128'h00530000, 128'h63ed6363};
        vecs[7] = '{1'b1, 1'b1, 128'h00000000, 128'h63636363};
        vecs[8] = '{1'b1, 1'b0, 128'h0f0e0d0c, 128'h76abd7fe};
`ifdef AES_SUB_SCHED_RR_EN
        exp_order = 3'b101;
`else
        exp_order = 3'b111;
`endif

        // Reset: readies forced low even with both requests valid.
        rst               = 1'b1;
        bus.blk_req_valid = 1'b1;
        bus.key_req_valid = 1'b1;
        bus.blk_enc       = 1'b1;
        bus.blk_in        = '0;
        bus.key_in        = '0;
        bus.blk_out_ready = 1'b1;
        bus.key_out_ready = 1'b1;
        cur_blk_exp       = '0;
        cur_key_exp       = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 128'({bus.blk_req_ready, bus.key_req_ready}), 128'(0));
        check_idle("rst_state");
        check("rst_outs", bus.blk_out | 128'(bus.key_out), 128'(0));
        @(posedge clk); #1;
        bus.blk_req_valid = 1'b0;
        bus.key_req_valid = 1'b0;
        rst               = 1'b0;

        // Contention over three jobs, starting from the reset pointer.
        @(posedge clk); #1;
        bus.blk_req_valid = 1'b1;
        bus.blk_in        = '0;
        bus.blk_enc       = 1'b1;
        cur_blk_exp       = {16{8'h63}};
        bus.key_req_valid = 1'b1;
        bus.key_in        = 32'h00530000;
        cur_key_exp       = 32'h63ed6363;
        acc_q.delete();
        n = 0;
        while (acc_q.size() < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        bus.blk_req_valid = 1'b0;
        bus.key_req_valid = 1'b0;
        check("arb_count", 128'(acc_q.size()), 128'(3));
        for (int i = 0; i < 3 && i < acc_q.size(); i++) begin
            check($sformatf("arb_order_%0d", i), 128'(acc_q[i]), 128'(exp_order[i]));
        end
        drain();

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Backpressure on the block output stalls everything.
        @(posedge clk); #1;
        bus.blk_req_valid = 1'b1;
        bus.blk_in        = {16{8'h53}};
        bus.blk_enc       = 1'b1;
        cur_blk_exp       = {16{8'hed}};
        wait_accept(1'b0);
        @(posedge clk); #1;
        bus.blk_req_valid = 1'b0;
        bus.blk_out_ready = 1'b0;
        wait_done(1'b0, lat);
        check("bp_latency", 128'(lat), 128'(NCHUNK));
        @(posedge clk); #1;
        bus.key_req_valid = 1'b1;
        bus.key_in        = 32'h00530000;
        cur_key_exp       = 32'h63ed6363;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", 128'(bus.blk_out_valid), 128'(1));
            check("bp_data", bus.blk_out, {16{8'hed}});
            check("bp_ready", 128'({bus.blk_req_ready, bus.key_req_ready}), 128'(0));
        end
        @(posedge clk); #1;
        bus.blk_out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_idle", 128'({busy, bus.blk_out_valid}), 128'(0));
        check("bp_release_ready", 128'(bus.key_req_ready), 128'(1));
        @(posedge clk); #1;
        bus.key_req_valid = 1'b0;
        wait_done(1'b1, lat);
        check("bp_key_latency", 128'(lat), 128'(1));
        drain();

        // Reset in the second BLK_RUN cycle aborts the job.
        @(posedge clk); #1;
        bus.blk_req_valid = 1'b1;
        bus.blk_in        = {16{8'h53}};
        bus.blk_enc       = 1'b1;
        cur_blk_exp       = {16{8'hed}};
        wait_accept(1'b0);
        @(posedge clk); #1;
        bus.blk_req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_blk.delete();
        bus.blk_req_valid = 1'b1;
        bus.blk_in        = '0;
        bus.blk_enc       = 1'b1;
        cur_blk_exp       = {16{8'h63}};
        @(negedge clk);
        check("mid_rst_ready", 128'(bus.blk_req_ready), 128'(0));
        check_idle("mid_rst_state");
        check("mid_rst_outs", bus.blk_out | 128'(bus.key_out), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        wait_accept(1'b0);
        @(posedge clk); #1;
        bus.blk_req_valid = 1'b0;
        wait_done(1'b0, lat);
        check("post_rst_latency", 128'(lat), 128'(NCHUNK));
        @(negedge clk);
        check_idle("post_rst_idle");
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_sub_bytes_sched.md
Name: aes_sub_bytes_sched

Overview:
Time-multiplexed SubBytes engine with a reduced bank of S-box lanes. The bank is shared between two requesters:
- the round datapath: 128-bit state, forward or inverse S-box;
- key expansion: 32-bit SubWord, always forward S-box.
Each lane holds one aes_sbox and one aes_inv_sbox. The block arbitrates between the requesters, sequences each job over the lanes chunk by chunk, and returns results on valid/ready interfaces. It sits between the round controller / key scheduler and the S-box bank, and replaces 16 parallel S-box pairs in area-reduced builds.

Parameters:
- LANES, 4: bytes substituted per cycle. Legal values 4, 8, 16; any other value raises an elaboration $error.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- blk_req_valid  in  1  round-state request valid
- blk_req_ready  out  1  round-state request accepted when valid&&ready
- blk_enc  in  1  1 = forward S-box, 0 = inverse S-box; sampled at accept
- blk_in  in  128  state to substitute
- blk_out_valid  out  1  result valid
- blk_out_ready  in  1  consumer ready
- blk_out  out  128  substituted state
- key_req_valid  in  1  SubWord request valid
- key_req_ready  out  1  SubWord request accepted when valid&&ready
- key_in  in  32  word to substitute
- key_out_valid  out  1  result valid
- key_out_ready  in  1  consumer ready
- key_out  out  32  substituted word
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: state IDLE; blk_out_valid=0, key_out_valid=0; blk_out=0, key_out=0; chunk counter 0; round-robin pointer favours key.
- While rst is high, both req_ready outputs are forced to 0.
- Byte i occupies bits [8i+:8]. Chunk c covers bytes c*LANES .. c*LANES+LANES-1, processed LSB chunk first.
- NCHUNK = 16/LANES for a block job. A key job is always 1 chunk (LANES >= 4).
- States:
  - IDLE
  - BLK_RUN
  - KEY_RUN
  - BLK_DONE
  - KEY_DONE
- Request ready is combinational, asserted only in IDLE: req_ready_x = (state==IDLE) && grant_x.
  - Grant goes to the only valid requester.
  - If both are valid, arbitration decides (see Optional Feature).
  - At most one ready is high in any cycle.
- IDLE -> BLK_RUN on block accept:
  - latch blk_in into the work register; latch blk_enc into the mode register;
  - clear the chunk counter.
- IDLE -> KEY_RUN on key accept:
  - latch key_in into bits [31:0] of the work register;
  - force the mode register to forward.
- BLK_RUN:
  - each cycle replaces chunk c of the work register in place with its lane outputs (mode selects sbox or inv_sbox);
  - c increments each cycle; at c==NCHUNK-1, go to BLK_DONE.
- KEY_RUN: one cycle substitutes bytes 0..3, then go to KEY_DONE.
- Latency: counting from the accept edge, blk_out_valid rises NCHUNK edges later (4 for LANES=4) and key_out_valid rises 1 edge later.
- DONE states:
  - out_valid is held high and out data is held stable until out_ready.
  - On the valid&&ready edge, out_valid drops and the state returns to IDLE.
  - A new request can be accepted in the cycle after the handshake (no bypass).
- out_ready asserted before out_valid has no effect.
- Backpressure on one output stalls the whole engine. No second job starts while a result is pending.
- Mode is fixed for the whole job. blk_enc and blk_in changes after accept are ignored.
- Reset asserted mid-job aborts it immediately. No output is produced and state returns to IDLE.
- Invariants: blk_out_valid and key_out_valid are never both high. busy = (state != IDLE).

Optional Feature:
- Macro AES_SUB_SCHED_RR_EN.
- Undefined: fixed priority, key wins whenever both requesters are valid in IDLE.
- Defined: round-robin. A 1-bit pointer toggles to the non-winner on every contended grant; uncontended grants leave it unchanged. The reset pointer favours key.

Test Plan:
- LANES=4, block all 0x00, blk_enc=1 -> blk_out all 0x63; blk_out_valid 4 edges after accept; busy high for 4 cycles plus the DONE cycle.
- Block all 0x63, blk_enc=0 -> blk_out all 0x00. Block bytes 0x53, blk_enc=1 -> all 0xed. Repeat the block cases with LANES=8 (latency 2) and LANES=16 (latency 1).
- key_in=0x00530000 -> key_out=0x63ed6363 with key_out_valid 1 edge after accept. blk_enc toggling during the key job has no effect.
- Both requests valid in IDLE for 3 consecutive jobs:
  - without the macro: key, key, key (block starved while key stays valid);
  - with AES_SUB_SCHED_RR_EN: key, block, key.
- blk_out_ready held low for 5 cycles after valid -> blk_out stable and blk_out_valid high throughout; both req_ready low; release -> IDLE the next cycle.
- rst pulsed at the 2nd BLK_RUN cycle -> no blk_out_valid; outputs return to 0. A following request with all 0x00 completes correctly with all 0x63.
